paddle_array_ctrl: RTL
======================

PADDLE_ARRAY_CTRL -- requirements
Module: paddle_array_ctrl

Interface
REQ-001 SHALL have parameter NUM_PADDLES, default 2, number of paddles; legal range 1..4.
REQ-002 SHALL have parameter HMAX, default 800, total horizontal counts per line.
REQ-003 SHALL have parameter VMAX, default 525, total lines per frame.
REQ-004 SHALL have parameter H_ACTIVE, default 640, visible columns.
REQ-005 SHALL have parameter V_ACTIVE, default 480, visible rows.
REQ-006 SHALL have parameter PADDLE_H, default 64, paddle height in rows.
REQ-007 SHALL have parameter PADDLE_W, default 8, paddle width in columns.
REQ-008 SHALL have parameter X_MARGIN, default 16, left edge of paddle 0.
REQ-009 SHALL have parameter STEP, default 4, rows moved per frame.
REQ-010 i_Clk  in  1  pixel clock; single clock domain.
REQ-011 i_Reset_n  in  1  reset, asynchronous, active-low.
REQ-012 i_H_count  in  clog2(HMAX)  current column from frame counter.
REQ-013 i_V_count  in  clog2(VMAX)  current row from frame counter.
REQ-014 i_Up / i_Down  in  NUM_PADDLES each  debounced level controls, bit k = paddle k.
REQ-015 i_Auto  in  NUM_PADDLES  bit k set: paddle k tracks i_Ball_Y instead of buttons.
REQ-016 i_Ball_Y  in  clog2(V_ACTIVE)  ball top row, for auto mode.
REQ-017 i_Ready / i_Start / i_Game_Over  in  1 each  game-flow levels.
REQ-018 o_Draw_Paddle  out  NUM_PADDLES  bit k high when current pixel lies in paddle k.
REQ-019 o_Draw_Any  out  1  OR of o_Draw_Paddle.
REQ-020 o_V_pos  out  NUM_PADDLES*clog2(V_ACTIVE)  packed paddle top rows, paddle k at slice k.
REQ-021 o_State  out  2  game state encoding.

Function
REQ-022 FSM states SHALL be IDLE=0, READY=1, PLAY=2; IDLE->READY on i_Ready, READY->PLAY on i_Start, PLAY->IDLE on i_Game_Over, READY->IDLE on i_Ready low; i_Game_Over SHALL take priority over all other transitions.
REQ-023 In IDLE and READY every V_pos SHALL be held at CENTRE=(V_ACTIVE-PADDLE_H)/2 (208 default).
REQ-024 Frame tick SHALL be a one-cycle internal pulse when i_H_count==0 and i_V_count==V_ACTIVE; positions SHALL update only on that tick, only in PLAY.
REQ-025 Manual paddle: up only -> V_pos-STEP; down only -> V_pos+STEP; both or neither -> no change.
REQ-026 Auto paddle: target = i_Ball_Y - PADDLE_H/2 (signed); move STEP toward target; if |target-V_pos|<STEP, no move.
REQ-027 V_pos SHALL saturate to [0, V_ACTIVE-PADDLE_H] (0..416 default); arithmetic SHALL use one extra sign bit, no wrap.
REQ-028 Paddle k column X_k = X_MARGIN + k*((H_ACTIVE-2*X_MARGIN-PADDLE_W)/(NUM_PADDLES-1)), integer division; NUM_PADDLES=1 gives X_0=X_MARGIN.
REQ-029 o_Draw_Paddle[k] SHALL be registered, asserted one cycle after counts satisfy X_k<=H<X_k+PADDLE_W and V_pos<=V<V_pos+PADDLE_H.
REQ-030 o_Draw_Any SHALL be registered in the same cycle as o_Draw_Paddle.
REQ-031 o_V_pos and o_State SHALL be registered outputs, updated the cycle after the tick or transition.
REQ-032 Draw SHALL be low outside H<H_ACTIVE, V<V_ACTIVE regardless of position.

Reset
REQ-033 Asserting i_Reset_n low SHALL immediately force state IDLE, all V_pos=CENTRE, o_Draw_Paddle=0, o_Draw_Any=0, o_State=0.
REQ-034 Reset mid-PLAY SHALL discard motion; after release, first move requires READY->PLAY again.

Structure
REQ-035 State encoding, CENTRE/MAX derivations and X_k function SHALL live in shared package pong_pkg.
REQ-036 Per-paddle position/draw logic SHALL be one sub-module paddle_unit, instantiated NUM_PADDLES times by generate.

Verification
REQ-037 Reset then i_Ready=1, i_Start=1, i_Up[0] held 60 frames -> V_pos[0] 208,204,...,0 after 52 ticks, stays 0.
REQ-038 PLAY, i_Down[1] held 60 frames -> V_pos[1] saturates at 416, never 420.
REQ-039 PLAY, i_Up[0]=i_Down[0]=1 for 5 frames -> V_pos[0] unchanged at 208.
REQ-040 PLAY, i_Auto[1]=1, i_Ball_Y=400 -> V_pos[1] rises by 4/frame to 368, then holds (diff<4).
REQ-041 PLAY with V_pos[0]=100, i_Game_Over pulse -> o_State=0 next cycle, V_pos[0]=208; o_Draw_Paddle[0] high one cycle after H=16,V=208.
REQ-042 i_Reset_n low mid-frame in PLAY -> outputs at reset values same cycle, no clock needed.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared definitions for the paddle array: game state encoding, the
// derived paddle row limits and the paddle column placement function.
package pong_pkg;

  // Game flow states; the numeric values are visible on o_State.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READY = 2'd1,
    ST_PLAY  = 2'd2
  } game_state_t;

  // Row at which every paddle rests outside of play.
  function automatic int centre_row(input int v_active, input int paddle_h);
    return (v_active - paddle_h) / 2;
  endfunction

  // Lowest legal paddle top row (paddle bottom touches the last visible row).
  function automatic int max_row(input int v_active, input int paddle_h);
    return v_active - paddle_h;
  endfunction

  // Left column of paddle k; paddles are spread evenly from the left margin
  // to the mirrored right margin, a single paddle sits at the left margin.
  function automatic int paddle_col(input int k, input int num_paddles,
                                    input int h_active, input int x_margin,
                                    input int paddle_w);
    if (num_paddles <= 1) begin
      return x_margin;
    end
    return x_margin + k * ((h_active - 2 * x_margin - paddle_w) / (num_paddles - 1));
  endfunction

endpackage

// File: rtl/paddle_unit.sv
// One paddle: vertical position register with manual/auto motion and
// saturation, plus the per-pixel hit test and its registered draw bit.
module paddle_unit
  import pong_pkg::*;
#(
  parameter int HMAX     = 800,
  parameter int VMAX     = 525,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int PADDLE_H = 64,
  parameter int PADDLE_W = 8,
  parameter int STEP     = 4,
  parameter int X_POS    = 16,
  parameter int HW       = $clog2(HMAX),
  parameter int VCW      = $clog2(VMAX),
  parameter int VW       = $clog2(V_ACTIVE)
) (
  input  logic           i_Clk,
  input  logic           i_Reset_n,
  input  logic [HW-1:0]  h_count,
  input  logic [VCW-1:0] v_count,
  input  logic           up,
  input  logic           down,
  input  logic           auto_mode,
  input  logic [VW-1:0]  ball_y,
  input  logic           hold_centre,
  input  logic           move_en,
  output logic [VW-1:0]  v_pos,
  output logic           hit,
  output logic           draw
);

  // Two spare bits: one sign bit plus headroom so pos +/- STEP never wraps.
  localparam int SW = VW + 2;

  localparam logic [VW-1:0]        CENTRE_V = VW'(centre_row(V_ACTIVE, PADDLE_H));
  localparam logic signed [SW-1:0] MAX_S    = SW'(max_row(V_ACTIVE, PADDLE_H));
  localparam logic signed [SW-1:0] STEP_S   = SW'(STEP);
  localparam logic signed [SW-1:0] NSTEP_S  = -SW'(STEP);
  localparam logic signed [SW-1:0] HALF_S   = SW'(PADDLE_H / 2);
  localparam logic signed [SW-1:0] ZERO_S   = '0;

  localparam logic [HW:0]  X_LO    = (HW + 1)'(X_POS);
  localparam logic [HW:0]  X_HI    = (HW + 1)'(X_POS + PADDLE_W);
  localparam logic [HW-1:0] H_VIS  = HW'(H_ACTIVE);
  localparam logic [VCW-1:0] V_VIS = VCW'(V_ACTIVE);

  logic [VW-1:0]        v_pos_reg;
  logic [VW-1:0]        v_pos_next;
  logic signed [SW-1:0] pos_s;
  logic signed [SW-1:0] target_s;
  logic signed [SW-1:0] diff_s;
  logic signed [SW-1:0] moved_s;
  logic                 draw_reg;
  logic                 hit_next;

  assign pos_s    = $signed({2'b00, v_pos_reg});
  assign target_s = $signed({2'b00, ball_y}) - HALF_S;
  assign diff_s   = target_s - pos_s;

  // Candidate next row: one STEP of motion, then clamp into the legal range.
  always_comb begin
    moved_s = pos_s;
    if (auto_mode) begin
      if (diff_s >= STEP_S) begin
        moved_s = pos_s + STEP_S;
      end else if (diff_s <= NSTEP_S) begin
        moved_s = pos_s - STEP_S;
      end
    end else if (up && !down) begin
      moved_s = pos_s - STEP_S;
    end else if (down && !up) begin
      moved_s = pos_s + STEP_S;
    end

    if (moved_s < ZERO_S) begin
      v_pos_next = '0;
    end else if (moved_s > MAX_S) begin
      v_pos_next = MAX_S[VW-1:0];
    end else begin
      v_pos_next = moved_s[VW-1:0];
    end
  end

  // Position register: parked at centre outside play, steps on frame ticks.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      v_pos_reg <= CENTRE_V;
    end else if (hold_centre) begin
      v_pos_reg <= CENTRE_V;
    end else if (move_en) begin
      v_pos_reg <= v_pos_next;
    end
  end

  // Pixel hit test against the current position, masked to the visible area.
  always_comb begin
    logic [HW:0]  h_ext;
    logic [VCW:0] v_ext;
    logic [VCW:0] v_top;
    logic [VCW:0] v_bot;
    h_ext    = {1'b0, h_count};
    v_ext    = {1'b0, v_count};
    v_top    = (VCW + 1)'(v_pos_reg);
    v_bot    = v_top + (VCW + 1)'(PADDLE_H);
    hit_next = (h_count < H_VIS) && (v_count < V_VIS) &&
               (h_ext >= X_LO) && (h_ext < X_HI) &&
               (v_ext >= v_top) && (v_ext < v_bot);
  end

  // Draw bit lags the counts by one cycle.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      draw_reg <= 1'b0;
    end else begin
      draw_reg <= hit_next;
    end
  end

  assign v_pos = v_pos_reg;
  assign hit   = hit_next;
  assign draw  = draw_reg;

endmodule

// File: rtl/paddle_array_ctrl.sv
// Paddle array controller: game-flow FSM, frame tick detection and a
// generated row of paddle units sharing the frame counter and ball row.
module paddle_array_ctrl
  import pong_pkg::*;
#(
  parameter int NUM_PADDLES = 2,
  parameter int HMAX        = 800,
  parameter int VMAX        = 525,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int PADDLE_H    = 64,
  parameter int PADDLE_W    = 8,
  parameter int X_MARGIN    = 16,
  parameter int STEP        = 4
) (
  input  logic                                   i_Clk,
  input  logic                                   i_Reset_n,
  input  logic [$clog2(HMAX)-1:0]                i_H_count,
  input  logic [$clog2(VMAX)-1:0]                i_V_count,
  input  logic [NUM_PADDLES-1:0]                 i_Up,
  input  logic [NUM_PADDLES-1:0]                 i_Down,
  input  logic [NUM_PADDLES-1:0]                 i_Auto,
  input  logic [$clog2(V_ACTIVE)-1:0]            i_Ball_Y,
  input  logic                                   i_Ready,
  input  logic                                   i_Start,
  input  logic                                   i_Game_Over,
  output logic [NUM_PADDLES-1:0]                 o_Draw_Paddle,
  output logic                                   o_Draw_Any,
  output logic [NUM_PADDLES*$clog2(V_ACTIVE)-1:0] o_V_pos,
  output logic [1:0]                             o_State
);

  localparam int HW  = $clog2(HMAX);
  localparam int VCW = $clog2(VMAX);
  localparam int VW  = $clog2(V_ACTIVE);

  localparam logic [VCW-1:0] TICK_ROW = VCW'(V_ACTIVE);

  game_state_t state_reg;
  game_state_t state_next;

  logic                   frame_tick;
  logic                   hold_centre;
  logic                   move_en;
  logic                   draw_any_reg;
  logic [NUM_PADDLES-1:0] hit_w;
  logic [NUM_PADDLES-1:0] draw_w;
  logic [VW-1:0]          v_pos_w [NUM_PADDLES];

  // State register; reset drops straight back to IDLE.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; game over wins from any state.
  always_comb begin
    state_next = state_reg;
    if (i_Game_Over) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (i_Ready) state_next = ST_READY;
        end
        ST_READY: begin
          if (!i_Ready) begin
            state_next = ST_IDLE;
          end else if (i_Start) begin
            state_next = ST_PLAY;
          end
        end
        ST_PLAY: begin
          state_next = ST_PLAY;
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  // First blanking pixel of the frame: one-cycle tick per frame.
  assign frame_tick = (i_H_count == '0) && (i_V_count == TICK_ROW);

  // Centring follows the incoming state so positions snap back in the same
  // cycle o_State leaves PLAY; motion needs PLAY both now and next.
  assign hold_centre = (state_next != ST_PLAY);
  assign move_en     = frame_tick && (state_reg == ST_PLAY);

  for (genvar gi = 0; gi < NUM_PADDLES; gi++) begin : g_paddle
    paddle_unit #(
      .HMAX     (HMAX),
      .VMAX     (VMAX),
      .H_ACTIVE (H_ACTIVE),
      .V_ACTIVE (V_ACTIVE),
      .PADDLE_H (PADDLE_H),
      .PADDLE_W (PADDLE_W),
      .STEP     (STEP),
      .X_POS    (paddle_col(gi, NUM_PADDLES, H_ACTIVE, X_MARGIN, PADDLE_W)),
      .HW       (HW),
      .VCW      (VCW),
      .VW       (VW)
    ) u_paddle (
      .i_Clk       (i_Clk),
      .i_Reset_n   (i_Reset_n),
      .h_count     (i_H_count),
      .v_count     (i_V_count),
      .up          (i_Up[gi]),
      .down        (i_Down[gi]),
      .auto_mode   (i_Auto[gi]),
      .ball_y      (i_Ball_Y),
      .hold_centre (hold_centre),
      .move_en     (move_en),
      .v_pos       (v_pos_w[gi]),
      .hit         (hit_w[gi]),
      .draw        (draw_w[gi])
    );

    assign o_V_pos[gi*VW +: VW] = v_pos_w[gi];
  end

  // Combined draw flag registered from the same hit terms as the per-paddle bits.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      draw_any_reg <= 1'b0;
    end else begin
      draw_any_reg <= |hit_w;
    end
  end

  assign o_Draw_Paddle = draw_w;
  assign o_Draw_Any    = draw_any_reg;
  assign o_State       = state_reg;

endmodule
